// File: rtl/mmio_controller_pkg.sv
// Address map and control-word layout for the MMIO stage in the 0x8000_00xx window.
package mmio_controller_pkg;

  localparam logic [3:0]  MMIO_REGION = 4'b1000;

  localparam logic [31:0] UART_CTRL = 32'h8000_0000;
  localparam logic [31:0] UART_RX   = 32'h8000_0004;
  localparam logic [31:0] UART_TX   = 32'h8000_0008;
  localparam logic [31:0] CYCLE     = 32'h8000_0010;
  localparam logic [31:0] INSTRET   = 32'h8000_0014;
  localparam logic [31:0] CNT_RST   = 32'h8000_0018;

  localparam int CTRL_TX_READY = 0;
  localparam int CTRL_RX_VALID = 1;

  // Only the low byte selects a register once the region nibble has matched.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] reg_addr);
    return addr[7:0] == reg_addr[7:0];
  endfunction

endpackage

// File: rtl/mmio_controller_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and a registered occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_wr, do_rd;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_controller.sv
// MMIO stage: UART RX FIFO, UART TX holding register and cycle/instret counters,
// presented as three registered read words with one cycle of latency.
module mmio_controller
  import mmio_controller_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int RX_AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [7:0]  store_data,
  input  logic        inst_retire,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [31:0] uart_data_0_out,
  output logic [31:0] uart_data_4_out,
  output logic [31:0] counter_data_out
);
  if ((1 << RX_AW) != RX_DEPTH) begin : g_bad_cfg
    $error("RX_DEPTH must equal 2**RX_AW");
  end

  logic        in_io, is_store, is_load;
  logic        tx_wr, cnt_clr, rx_pop;
  logic        rx_full, rx_empty, rx_push;
  logic [7:0]  rx_head;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [31:0] ctrl_word;
  logic        unused_addr;

  assign unused_addr = &{1'b0, mem_addr[27:8], mem_addr[1:0]};

  // A simultaneous load and store is a store, so it can never pop the FIFO.
  assign in_io    = mem_addr[31:28] == MMIO_REGION;
  assign is_store = in_io & mem_we;
  assign is_load  = in_io & mem_re & ~mem_we;
  assign tx_wr    = is_store & addr_hit(mem_addr, UART_TX) & ~uart_tx_valid;
  assign cnt_clr  = is_store & addr_hit(mem_addr, CNT_RST);
  assign rx_pop   = is_load & addr_hit(mem_addr, UART_RX);

  assign uart_rx_ready = ~rx_full;
  assign rx_push       = uart_rx_valid & ~rx_full;

  always_comb begin
    ctrl_word                = '0;
    ctrl_word[CTRL_TX_READY] = ~uart_tx_valid;
    ctrl_word[CTRL_RX_VALID] = ~rx_empty;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (rx_push),
    .din   (uart_rx_data),
    .rd_en (rx_pop),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
    end else if (tx_wr) begin
      uart_tx_valid <= 1'b1;
      uart_tx_data  <= store_data;
    end else if (uart_tx_valid & uart_tx_ready) begin
      uart_tx_valid <= 1'b0;
    end
  end

  // Counter clear wins over both increments on the same edge.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt   <= cycle_cnt + 32'd1;
      instret_cnt <= instret_cnt + {31'b0, inst_retire};
    end
  end

  // Read words reflect the state held before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_data_0_out  <= '0;
      uart_data_4_out  <= '0;
      counter_data_out <= '0;
    end else begin
      uart_data_0_out  <= ctrl_word;
      counter_data_out <= mem_addr[2] ? instret_cnt : cycle_cnt;
      if (rx_pop) uart_data_4_out <= rx_empty ? 32'd0 : {24'b0, rx_head};
    end
  end

endmodule

// File: tb/tb_mmio_controller.sv
// Bench for mmio_controller: vector table plus directed sequences, checked through an expectation queue.
module tb_mmio_controller;
  import mmio_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  store_data;
  logic        inst_retire;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid, uart_rx_ready;
  logic [31:0] uart_data_0_out, uart_data_4_out, counter_data_out;

  always #5 clk = ~clk;

  mmio_controller #(.RX_DEPTH(8), .RX_AW(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_addr         (mem_addr),
    .mem_re           (mem_re),
    .mem_we           (mem_we),
    .store_data       (store_data),
    .inst_retire      (inst_retire),
    .uart_tx_data     (uart_tx_data),
    .uart_tx_valid    (uart_tx_valid),
    .uart_tx_ready    (uart_tx_ready),
    .uart_rx_data     (uart_rx_data),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_ready    (uart_rx_ready),
    .uart_data_0_out  (uart_data_0_out),
    .uart_data_4_out  (uart_data_4_out),
    .counter_data_out (counter_data_out)
  );

  localparam int SEL_NONE = 0, SEL_CTRL = 1, SEL_RXD = 2, SEL_CNT = 3;

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    bit          re;
    bit          we;
    logic [31:0] addr;
    logic [7:0]  wd;
    bit          rxv;
    logic [7:0]  rxd;
    int          sel;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] out_of(input int sel);
    case (sel)
      SEL_CTRL: return uart_data_0_out;
      SEL_RXD:  return uart_data_4_out;
      default:  return counter_data_out;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expect_next(input string nm, input int sel, input logic [31:0] val);
    exp_t e;
    e.nm = nm; e.sel = sel; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.nm, out_of(e.sel), e.val);
    end
  endtask

  task automatic idle();
    mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; store_data = '0;
    uart_rx_valid = 1'b0; uart_rx_data = '0;
  endtask

  task automatic load(input logic [31:0] addr, input int sel, input logic [31:0] val, input string nm);
    mem_re = 1'b1; mem_addr = addr;
    expect_next(nm, sel, val);
    step();
    mem_re = 1'b0; mem_addr = '0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [7:0] data);
    mem_we = 1'b1; mem_addr = addr; store_data = data;
    step();
    mem_we = 1'b0; mem_addr = '0; store_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int NV = 20;
  vec_t vecs[NV];
  int   pushed;

  initial begin
    vecs[0]  = '{0, 0, 32'h0,         8'h00, 1, 8'h41, SEL_NONE, 32'h0,  "push_41"};
    vecs[1]  = '{0, 0, 32'h0,         8'h00, 1, 8'h42, SEL_NONE, 32'h0,  "push_42"};
    vecs[2]  = '{1, 0, UART_CTRL,     8'h00, 0, 8'h00, SEL_CTRL, 32'h3,  "ctrl_two_queued"};
    vecs[3]  = '{1, 0, UART_RX,       8'h00, 0, 8'h00, SEL_RXD,  32'h41, "pop_41"};
    vecs[4]  = '{1, 0, UART_RX,       8'h00, 0, 8'h00, SEL_RXD,  32'h42, "pop_42"};
    vecs[5]  = '{1, 0, UART_CTRL,     8'h00, 0, 8'h00, SEL_CTRL, 32'h1,  "ctrl_drained"};
    vecs[6]  = '{1, 0, UART_RX,       8'h00, 0, 8'h00, SEL_RXD,  32'h0,  "pop_empty"};
    vecs[7]  = '{1, 0, UART_RX,       8'h00, 1, 8'h77, SEL_RXD,  32'h0,  "pop_push_empty"};
    vecs[8]  = '{1, 0, UART_CTRL,     8'h00, 0, 8'h00, SEL_CTRL, 32'h3,  "ctrl_after_push_empty"};
    vecs[9]  = '{1, 0, UART_RX,       8'h00, 0, 8'h00, SEL_RXD,  32'h77, "pop_77"};
    vecs[10] = '{0, 0, 32'h0,         8'h00, 1, 8'h10, SEL_NONE, 32'h0,  "push_10"};
    vecs[11] = '{1, 0, UART_RX,       8'h00, 1, 8'h11, SEL_RXD,  32'h10, "pop_push_nonempty"};
    vecs[12] = '{1, 0, UART_RX,       8'h00, 0, 8'h00, SEL_RXD,  32'h11, "pop_11"};
    vecs[13] = '{1, 0, UART_CTRL,     8'h00, 0, 8'h00, SEL_CTRL, 32'h1,  "ctrl_empty_again"};
    vecs[14] = '{0, 0, 32'h0,         8'h00, 1, 8'h22, SEL_NONE, 32'h0,  "push_22"};
    vecs[15] = '{1, 1, UART_RX,       8'h00, 0, 8'h00, SEL_RXD,  32'h11, "re_we_no_pop"};
    vecs[16] = '{1, 0, UART_RX,       8'h00, 0, 8'h00, SEL_RXD,  32'h22, "pop_22"};
    vecs[17] = '{0, 0, 32'h0,         8'h00, 1, 8'h33, SEL_NONE, 32'h0,  "push_33"};
    vecs[18] = '{1, 0, 32'h0000_0004, 8'h00, 0, 8'h00, SEL_RXD,  32'h22, "out_of_region_no_pop"};
    vecs[19] = '{1, 0, UART_RX,       8'h00, 0, 8'h00, SEL_RXD,  32'h33, "pop_33"};

    idle();
    inst_retire   = 1'b0;
    uart_tx_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("rst_ctrl",     uart_data_0_out,  32'h0);
    check("rst_rxdata",   uart_data_4_out,  32'h0);
    check("rst_counter",  counter_data_out, 32'h0);
    check("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    rst = 1'b0;
    check("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);

    expect_next("first_counter", SEL_CNT, 32'h0);
    load(UART_CTRL, SEL_CTRL, 32'h1, "first_ctrl");

    for (int i = 0; i < NV; i++) begin
      mem_re = vecs[i].re; mem_we = vecs[i].we; mem_addr = vecs[i].addr;
      store_data = vecs[i].wd; uart_rx_valid = vecs[i].rxv; uart_rx_data = vecs[i].rxd;
      if (vecs[i].sel != SEL_NONE) expect_next(vecs[i].nm, vecs[i].sel, vecs[i].exp);
      step();
      idle();
    end
    load(UART_RX, SEL_RXD, 32'h0, "table_drained");

    // Fill the FIFO; the UART holds off the ninth byte while ready is low.
    pushed = 0;
    uart_rx_valid = 1'b1;
    for (int c = 0; c < 16 && pushed < 8; c++) begin
      uart_rx_data = 8'hA0 + 8'(pushed);
      if (uart_rx_ready) pushed++;
      step();
    end
    check("fill_count", 32'(pushed), 32'd8);
    check("full_ready_low", {31'b0, uart_rx_ready}, 32'h0);
    uart_rx_data = 8'hA8;
    repeat (2) step();
    check("full_ready_held", {31'b0, uart_rx_ready}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      mem_re = 1'b1; mem_addr = UART_RX;
      expect_next("fifo_order", SEL_RXD, {24'h0, 8'hA0 + 8'(i)});
      step();
      uart_rx_valid = 1'b0;
    end
    idle();
    load(UART_RX, SEL_RXD, 32'h0, "no_overflow_byte");
    check("drained_ready", {31'b0, uart_rx_ready}, 32'h1);

    // TX holding register with a slow UART.
    store(UART_TX, 8'h5A);
    check("tx_valid_set", {31'b0, uart_tx_valid}, 32'h1);
    check("tx_data", {24'h0, uart_tx_data}, 32'h5A);
    load(UART_CTRL, SEL_CTRL, 32'h0, "ctrl_tx_busy");
    store(UART_TX, 8'hA5);
    check("tx_drop_data", {24'h0, uart_tx_data}, 32'h5A);
    check("tx_drop_valid", {31'b0, uart_tx_valid}, 32'h1);
    uart_tx_ready = 1'b1;
    step();
    uart_tx_ready = 1'b0;
    check("tx_handshake_clear", {31'b0, uart_tx_valid}, 32'h0);
    load(UART_CTRL, SEL_CTRL, 32'h1, "ctrl_tx_free");
    store(32'h0000_0008, 8'h66);
    check("tx_out_of_region", {31'b0, uart_tx_valid}, 32'h0);

    // Counters.
    store(CNT_RST, 8'h00);
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i < 40);
      step();
    end
    inst_retire = 1'b0;
    load(CYCLE,   SEL_CNT, 32'd100, "cycle_100");
    load(INSTRET, SEL_CNT, 32'd40,  "instret_40");
    inst_retire = 1'b1;
    store(CNT_RST, 8'hFF);
    inst_retire = 1'b0;
    load(INSTRET, SEL_CNT, 32'd0, "instret_clear_beats_retire");
    load(CYCLE,   SEL_CNT, 32'd1, "cycle_after_clear");
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    load(CYCLE, SEL_CNT, 32'hFFFF_FFFF, "cycle_max");
    load(CYCLE, SEL_CNT, 32'h0,         "cycle_wrap");

    // Reset in the middle of a TX with three RX bytes queued.
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      uart_rx_data = 8'hC1 + 8'(i);
      step();
    end
    idle();
    load(UART_RX, SEL_RXD, 32'hC1, "pre_reset_pop");
    inst_retire = 1'b1;
    store(UART_TX, 8'h3C);
    inst_retire = 1'b0;
    check("pre_reset_tx_valid", {31'b0, uart_tx_valid}, 32'h1);
    rst = 1'b1;
    step();
    check("mid_rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("mid_rst_tx_data",  {24'h0, uart_tx_data}, 32'h0);
    check("mid_rst_ctrl",     uart_data_0_out,  32'h0);
    check("mid_rst_rxdata",   uart_data_4_out,  32'h0);
    check("mid_rst_counter",  counter_data_out, 32'h0);
    rst = 1'b0;
    load(UART_CTRL, SEL_CTRL, 32'h1, "post_rst_fifo_empty");
    load(INSTRET,   SEL_CNT,  32'h0, "post_rst_instret");
    load(UART_RX,   SEL_RXD,  32'h0, "post_rst_pop_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
